// File: rtl/fft_input_reorder.sv
// Ping-pong input buffer for a radix-2 FFT: streams samples in natural order and
// presents each complete frame in bit-reversed order as a parallel word array.
module fft_input_reorder #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data [SAMPLES-1:0],
    output logic             sof_err
);

    localparam int            AW      = $clog2(SAMPLES);
    localparam logic [AW-1:0] CNT_MAX = AW'(SAMPLES - 1);
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = {AW{1'b0}};
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] bank_q [1:0][SAMPLES-1:0];
    logic [WIDTH-1:0] bank_d [1:0][SAMPLES-1:0];
    logic [1:0]       full_q, full_d;
    logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             sof_err_q, sof_err_d;
    logic             accept_s;
    logic             release_s;
    logic             restart_s;
    logic [AW-1:0]    wr_idx_s;

    // Next-state logic: frame release on the read side, sample capture on the write side.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        sof_err_d = 1'b0;

        accept_s  = in_valid && !full_q[wr_bank_q];
        release_s = full_q[rd_bank_q] && frame_ready;
        // A start-of-frame in the middle of a frame restarts the current bank at slot 0.
        restart_s = accept_s && in_sof && (wr_cnt_q != {AW{1'b0}});
        wr_idx_s  = restart_s ? {AW{1'b0}} : bitrev(wr_cnt_q);

        if (release_s) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end

        // Write and release always target different banks, so both can land together.
        if (accept_s) begin
            bank_d[wr_bank_q][wr_idx_s] = in_data;
            if (restart_s) begin
                sof_err_d = 1'b1;
                wr_cnt_d  = CNT_ONE;
            end else if (wr_cnt_q == CNT_MAX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = {AW{1'b0}};
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // State registers; reset discards any buffered or pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < SAMPLES; i++) begin
                    bank_q[b][i] <= {WIDTH{1'b0}};
                end
            end
            full_q    <= 2'b00;
            wr_cnt_q  <= {AW{1'b0}};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            sof_err_q <= sof_err_d;
        end
    end

    // Outputs select directly from registered state.
    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        frame_valid = full_q[rd_bank_q];
        frame_data  = bank_q[rd_bank_q];
        sof_err     = sof_err_q;
    end

endmodule
